tbuf_bus_arbiter: RTL and testbench

Round-robin arbiter and driver controller for a shared tristate bus built from TBUFX1 cells (inverting, active-high EN). Each of N requesters owns one lane of W TBUFX1 cells. The block generates the one-hot EN vector and the pre-inverted A inputs so the bus carries true-polarity data. It inserts a mandatory all-drivers-off turnaround between owners so no two lanes ever drive the bus together.

---
 rtl/tbuf_bus_arbiter.sv | 91 +++++++++
 tb/tb_tbuf_bus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tbuf_bus_arbiter.sv
// tbuf_bus_arbiter: round-robin owner selection and TBUFX1 enable/data drive for a shared tristate bus
module tbuf_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] DIN,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   BUS_EN,
  output logic [N*W-1:0] BUS_A,
  output logic           BUSY
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n, owner, owner_n, win;
  logic [HW-1:0] hc, hc_n;
  logic [TW-1:0] tc, tc_n;
  logic [N-1:0]  gnt_n;
  logic          busy_n;
  assign BUS_EN = GNT;
  // first requester at or after ptr, wrapping explicitly at N
  always_comb begin
    win = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j -= N;
      if (REQ[j]) win = PW'(j);
    end
  end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    hc_n    = hc;
    tc_n    = tc;
    gnt_n   = GNT;
    busy_n  = BUSY;
    case (state)
      IDLE: if (|REQ) begin
        state_n = DRIVE;
        owner_n = win;
        gnt_n   = N'(1) << win;
        hc_n    = HW'(1);
        busy_n  = 1'b1;
      end
      DRIVE: if (REQ[owner] && hc < HW'(MAX_HOLD)) hc_n = hc + HW'(1);
      else begin
        state_n = TURN;
        gnt_n   = '0;
        ptr_n   = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
        tc_n    = TW'(1);
      end
      TURN: if (tc < TW'(TURN_CYC)) tc_n = tc + TW'(1);
      else begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // A is pre-inverted so the inverting TBUFX1 restores true-polarity data
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      hc    <= '0;
      tc    <= '0;
      GNT   <= '0;
      BUSY  <= 1'b0;
      BUS_A <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      hc    <= hc_n;
      tc    <= tc_n;
      GNT   <= gnt_n;
      BUSY  <= busy_n;
      BUS_A <= ~DIN;
    end
  end
endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// tb_tbuf_bus_arbiter: scoreboard bench for three arbiter configurations against a grant-level reference model
module tb_tbuf_bus_arbiter;
  typedef struct {
    int owner;
    int held;
    int gap;
    int ptr;
  } ms_t;
  typedef struct {
    logic [7:0]  gnt;
    logic        busy;
    logic [31:0] a;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic [23:0] din_c = '0;
  logic        fix_a5 = 1'b0;
  logic [3:0]  gnt_a, en_a, gnt_b, en_b;
  logic [2:0]  gnt_c, en_c;
  logic        busy_a, busy_b, busy_c;
  logic [31:0] a_a, a_b;
  logic [23:0] a_c;
  logic [7:0]  pen_a = '0, pen_b = '0, pen_c = '0;
  ms_t         sa, sb, sc;
  exp_t        qa[$], qb[$], qc[$];
  int          passed = 0, total = 0;
  always #5 clk = ~clk;
  tbuf_bus_arbiter #(.N(4), .W(8), .TURN_CYC(1), .MAX_HOLD(4)) dut_a (
    .CLK(clk), .RST(rst), .REQ(req), .DIN(din_a),
    .GNT(gnt_a), .BUS_EN(en_a), .BUS_A(a_a), .BUSY(busy_a));
  tbuf_bus_arbiter #(.N(4), .W(8), .TURN_CYC(3), .MAX_HOLD(4)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req), .DIN(din_b),
    .GNT(gnt_b), .BUS_EN(en_b), .BUS_A(a_b), .BUSY(busy_b));
  tbuf_bus_arbiter #(.N(3), .W(8), .TURN_CYC(1), .MAX_HOLD(4)) dut_c (
    .CLK(clk), .RST(rst), .REQ(req[2:0]), .DIN(din_c),
    .GNT(gnt_c), .BUS_EN(en_c), .BUS_A(a_c), .BUSY(busy_c));
  // one arbitration decision per edge: owner keeps the bus, hands it back, waits out the gap, or a new owner is chosen
  function automatic ms_t step(ms_t s, int n, int tcyc, int mh, logic [3:0] rq, logic r);
    if (r) begin
      s.owner = -1; s.held = 0; s.gap = 0; s.ptr = 0;
    end else if (s.owner >= 0) begin
      if (rq[s.owner] && s.held < mh) s.held++;
      else begin
        s.ptr = (s.owner + 1) % n; s.owner = -1; s.gap = tcyc;
      end
    end else if (s.gap > 0) s.gap--;
    else
      for (int k = 0; k < n; k++)
        if (rq[(s.ptr + k) % n]) begin
          s.owner = (s.ptr + k) % n; s.held = 1; break;
        end
    return s;
  endfunction
  function automatic exp_t mk(ms_t s, logic [31:0] a);
    exp_t e;
    e.gnt  = (s.owner >= 0) ? 8'(1 << s.owner) : 8'h0;
    e.busy = (s.owner >= 0) || (s.gap > 0);
    e.a    = a;
    return e;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic mon(input string t, input exp_t e, input logic [7:0] g, input logic [7:0] en,
                     input logic b, input logic [31:0] a, input logic [7:0] pen);
    check({t, ".gnt"}, 32'(g), 32'(e.gnt));
    check({t, ".en"}, 32'(en), 32'(e.gnt));
    check({t, ".busy"}, 32'(b), 32'(e.busy));
    check({t, ".bus_a"}, a, e.a);
    check({t, ".onehot"}, 32'($countones(en) <= 1), 32'(1));
    check({t, ".noswap"}, 32'(pen == 0 || en == 0 || en == pen), 32'(1));
  endtask
  task automatic cyc(input logic r, input logic [3:0] q, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst   = r;
      req   = q;
      din_a = $urandom;
      if (fix_a5) din_a[7:0] = 8'hA5;
      din_b = $urandom;
      din_c = 24'($urandom);
      sa = step(sa, 4, 1, 4, req, rst);
      sb = step(sb, 4, 3, 4, req, rst);
      sc = step(sc, 3, 1, 4, {1'b0, req[2:0]}, rst);
      qa.push_back(mk(sa, rst ? 32'h0 : ~din_a));
      qb.push_back(mk(sb, rst ? 32'h0 : ~din_b));
      qc.push_back(mk(sc, rst ? 32'h0 : {8'h0, ~din_c}));
    end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      mon("A", e, {4'h0, gnt_a}, {4'h0, en_a}, busy_a, a_a, pen_a);
      pen_a = {4'h0, en_a};
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      mon("B", e, {4'h0, gnt_b}, {4'h0, en_b}, busy_b, a_b, pen_b);
      pen_b = {4'h0, en_b};
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      mon("C", e, {5'h0, gnt_c}, {5'h0, en_c}, busy_c, {8'h0, a_c}, pen_c);
      pen_c = {5'h0, en_c};
    end
  end
  initial begin
    logic [3:0] rq;
    sa = '{-1, 0, 0, 0};
    sb = '{-1, 0, 0, 0};
    sc = '{-1, 0, 0, 0};
    cyc(1'b1, 4'b0000, 2);
    cyc(1'b0, 4'b0100, 3);
    cyc(1'b1, 4'b0100, 1);
    cyc(1'b0, 4'b0000, 4);
    fix_a5 = 1'b1;
    cyc(1'b0, 4'b0001, 12);
    fix_a5 = 1'b0;
    cyc(1'b0, 4'b1111, 30);
    cyc(1'b0, 4'b0000, 8);
    cyc(1'b0, 4'b0100, 1);
    cyc(1'b0, 4'b0000, 1);
    cyc(1'b0, 4'b1001, 10);
    cyc(1'b0, 4'b0000, 8);
    cyc(1'b0, 4'b0001, 3);
    cyc(1'b0, 4'b0010, 12);
    cyc(1'b0, 4'b0000, 8);
    cyc(1'b0, 4'b0100, 2);
    cyc(1'b0, 4'b0101, 12);
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      cyc($urandom_range(0, 99) == 0, rq, 1);
    end
    repeat (2) @(posedge clk);
    #2;
    check("A.drain", 32'(qa.size()), 32'(0));
    check("B.drain", 32'(qb.size()), 32'(0));
    check("C.drain", 32'(qc.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
